// File: rtl/psx_ddr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : psx_ddr_pkg
// Purpose  : Shared types, size encodings and byte-enable helper for the
//            multi-client PSX DDR bridge.
// Revision : 1.0 - initial release
// ============================================================================
package psx_ddr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WRITE   = 3'd1,
        ST_RD_REQ  = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_RD_DONE = 3'd4
    } state_t;

    localparam logic [1:0] SZ_8B  = 2'd0;
    localparam logic [1:0] SZ_32B = 2'd1;

    localparam int BEATS_PER_BLOCK = 4;

    // One halfword-enable bit covers two adjacent bytes of the 64-bit beat.
    function automatic logic [7:0] maskToByteEnable(input logic [3:0] halfMask);
        logic [7:0] be;
        for (int h = 0; h < 4; h++) begin
            be[2*h +: 2] = {2{halfMask[h]}};
        end
        return be;
    endfunction

endpackage
`default_nettype wire

// File: rtl/psx_ddr_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : psx_ddr_rr_arbiter
// Purpose  : Combinational round-robin / fixed-priority grant over requests.
// Revision : 1.0 - initial release
// ============================================================================
module psx_ddr_rr_arbiter #(
    parameter int NUM_CLIENTS = 2,
    parameter int FIXED_PRIO  = 0,
    parameter int ID_W        = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1
) (
    input  logic                   clk,
    input  logic                   i_rst,
    input  logic [NUM_CLIENTS-1:0] i_request,
    input  logic                   i_accept,
    output logic [NUM_CLIENTS-1:0] o_grantOneHot,
    output logic [ID_W-1:0]        o_grantIdx,
    output logic                   o_grantValid
);

    localparam logic [ID_W-1:0] c_LAST_RESET = ID_W'(NUM_CLIENTS - 1);

    logic [ID_W-1:0] r_lastGrant;
    logic [ID_W-1:0] w_anyIdx;
    logic [ID_W-1:0] w_hiIdx;
    logic            w_anyFound;
    logic            w_hiFound;

    // Descending scan: the last hit is the lowest index, overall and above last_grant.
    always_comb begin
        w_anyIdx   = '0;
        w_hiIdx    = '0;
        w_anyFound = 1'b0;
        w_hiFound  = 1'b0;
        for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
            if (i_request[i]) begin
                w_anyIdx   = ID_W'(i);
                w_anyFound = 1'b1;
                if (i > int'(r_lastGrant)) begin
                    w_hiIdx   = ID_W'(i);
                    w_hiFound = 1'b1;
                end
            end
        end
    end

    assign o_grantIdx    = (FIXED_PRIO == 0 && w_hiFound) ? w_hiIdx : w_anyIdx;
    assign o_grantValid  = w_anyFound;
    assign o_grantOneHot = w_anyFound ? (NUM_CLIENTS'(1) << o_grantIdx) : '0;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_lastGrant <= c_LAST_RESET;
        end else if (i_accept && o_grantValid) begin
            r_lastGrant <= o_grantIdx;
        end
    end

endmodule
`default_nettype wire

// File: rtl/psx_ddr_mc_bridge.sv
`default_nettype none
// ============================================================================
// Module   : psx_ddr_mc_bridge
// Purpose  : Arbitrates N 32-byte-block clients onto one 64-bit Avalon-MM port.
// Revision : 1.0 - initial release
// ============================================================================
module psx_ddr_mc_bridge
    import psx_ddr_pkg::*;
#(
    parameter int NUM_CLIENTS  = 2,
    parameter int ADDR_W       = 15,
    parameter int FIXED_PRIO   = 0,
    localparam int ID_W        = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1
) (
    input  logic                          clk,
    input  logic                          i_rst,
    input  logic [NUM_CLIENTS-1:0]        i_command,
    input  logic [NUM_CLIENTS-1:0]        i_writeElseRead,
    input  logic [2*NUM_CLIENTS-1:0]      i_commandSize,
    input  logic [NUM_CLIENTS*ADDR_W-1:0] i_targetAddr,
    input  logic [3*NUM_CLIENTS-1:0]      i_subAddr,
    input  logic [16*NUM_CLIENTS-1:0]     i_writeMask,
    input  logic [256*NUM_CLIENTS-1:0]    i_dataClient,
    output logic [NUM_CLIENTS-1:0]        o_busyClient,
    output logic [NUM_CLIENTS-1:0]        o_dataValidClient,
    output logic [255:0]                  o_dataClient,
    output logic [ID_W-1:0]               o_grantId,
    output logic                          o_active,
    output logic [ADDR_W+1:0]             o_targetAddr,
    output logic [2:0]                    o_burstLength,
    input  logic                          i_busyMem,
    output logic                          o_writeEnableMem,
    output logic                          o_readEnableMem,
    output logic [63:0]                   o_dataMem,
    output logic [7:0]                    o_byteEnableMem,
    input  logic                          i_dataValidMem,
    input  logic [63:0]                   i_dataMem
);

    state_t                   r_state;
    state_t                   w_nextState;
    logic                     r_isWrite;
    logic                     r_is32;
    logic [ADDR_W-1:0]        r_addr;
    logic [1:0]               r_lane8;
    logic [15:0]              r_mask;
    logic [255:0]             r_wdata;
    logic [255:0]             r_rdata;
    logic [ID_W-1:0]          r_grantId;
    logic [1:0]               r_beat;

    logic [NUM_CLIENTS-1:0]   w_grantOneHot;
    logic [ID_W-1:0]          w_grantIdx;
    logic                     w_grantValid;
    logic                     w_accept;
    logic [1:0]               w_lane;
    logic                     w_lastBeat;
    logic                     w_unusedSubLsb;

    assign w_unusedSubLsb = ^i_subAddr;

    psx_ddr_rr_arbiter #(
        .NUM_CLIENTS (NUM_CLIENTS),
        .FIXED_PRIO  (FIXED_PRIO),
        .ID_W        (ID_W)
    ) u_arbiter (
        .clk           (clk),
        .i_rst         (i_rst),
        .i_request     (i_command),
        .i_accept      (w_accept),
        .o_grantOneHot (w_grantOneHot),
        .o_grantIdx    (w_grantIdx),
        .o_grantValid  (w_grantValid)
    );

    assign w_accept   = (r_state == ST_IDLE) && !i_rst && w_grantValid;
    assign w_lane     = r_is32 ? r_beat : r_lane8;
    assign w_lastBeat = !r_is32 || (r_beat == 2'(BEATS_PER_BLOCK - 1));

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState       = r_state;
        o_busyClient      = '1;
        o_writeEnableMem  = 1'b0;
        o_readEnableMem   = 1'b0;
        o_dataValidClient = '0;
        case (r_state)
            ST_IDLE: begin
                if (!i_rst) begin
                    o_busyClient = ~w_grantOneHot;
                end
                if (w_accept) begin
                    w_nextState = i_writeElseRead[w_grantIdx] ? ST_WRITE : ST_RD_REQ;
                end
            end
            ST_WRITE: begin
                o_writeEnableMem = 1'b1;
                if (!i_busyMem && w_lastBeat) begin
                    w_nextState = ST_IDLE;
                end
            end
            ST_RD_REQ: begin
                o_readEnableMem = 1'b1;
                if (!i_busyMem) begin
                    w_nextState = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (i_dataValidMem && w_lastBeat) begin
                    w_nextState = ST_RD_DONE;
                end
            end
            ST_RD_DONE: begin
                o_dataValidClient = NUM_CLIENTS'(1) << r_grantId;
                w_nextState       = ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Command register and beat counter; read lanes not hit keep old data.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_isWrite <= 1'b0;
            r_is32    <= 1'b0;
            r_addr    <= '0;
            r_lane8   <= '0;
            r_mask    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_grantId <= '0;
            r_beat    <= '0;
        end else begin
            if (w_accept) begin
                r_isWrite <= i_writeElseRead[w_grantIdx];
                r_is32    <= (i_commandSize[2*w_grantIdx +: 2] != SZ_8B);
                r_addr    <= i_targetAddr[ADDR_W*w_grantIdx +: ADDR_W];
                r_lane8   <= i_subAddr[3*w_grantIdx+1 +: 2];
                r_mask    <= i_writeMask[16*w_grantIdx +: 16];
                r_wdata   <= i_dataClient[256*w_grantIdx +: 256];
                r_grantId <= w_grantIdx;
                r_beat    <= '0;
            end
            if ((r_state == ST_WRITE && !i_busyMem) ||
                (r_state == ST_RD_WAIT && i_dataValidMem)) begin
                r_beat <= r_beat + 2'd1;
            end
            if (r_state == ST_RD_WAIT && i_dataValidMem) begin
                r_rdata[64*w_lane +: 64] <= i_dataMem;
            end
        end
    end

    assign o_dataClient    = r_rdata;
    assign o_grantId       = r_grantId;
    assign o_active        = (r_state != ST_IDLE);
    assign o_targetAddr    = {r_addr, (r_is32 ? 2'b00 : r_lane8)};
    assign o_burstLength   = r_is32 ? 3'd4 : 3'd1;
    assign o_dataMem       = o_writeEnableMem ? r_wdata[64*w_lane +: 64] : 64'd0;
    assign o_byteEnableMem = o_writeEnableMem ? maskToByteEnable(r_mask[4*w_lane +: 4]) : 8'd0;

endmodule
`default_nettype wire

// File: tb/tb_psx_ddr_mc_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_psx_ddr_mc_bridge
// Purpose  : Self-checking bench for psx_ddr_mc_bridge (RR and fixed priority).
// Revision : 1.0 - initial release
// ============================================================================
module tb_psx_ddr_mc_bridge;

    localparam int N  = 3;
    localparam int AW = 15;

    logic              clk = 1'b0;
    logic              r_rst = 1'b1;
    logic [N-1:0]      r_cmd = '0;
    logic [N-1:0]      r_wer = '0;
    logic [2*N-1:0]    r_csz = '0;
    logic [N*AW-1:0]   r_taddr = '0;
    logic [3*N-1:0]    r_sub = '0;
    logic [16*N-1:0]   r_mask = '0;
    logic [256*N-1:0]  r_wdata = '0;
    logic              r_busyMem = 1'b0;
    logic              r_dvMem = 1'b0;
    logic [63:0]       r_dMem = '0;

    logic [N-1:0]  w_busy, w_dvC, w_busyF, w_dvCF;
    logic [255:0]  w_dC, w_dCF;
    logic [1:0]    w_gId, w_gIdF;
    logic          w_act, w_actF, w_we, w_weF, w_re, w_reF;
    logic [AW+1:0] w_tAddr, w_tAddrF;
    logic [2:0]    w_bl, w_blF;
    logic [63:0]   w_dm, w_dmF;
    logic [7:0]    w_be, w_beF;

    int tests = 0;
    int fails = 0;
    logic [63:0] mLane [4];

    always #5 clk = ~clk;

    psx_ddr_mc_bridge #(.NUM_CLIENTS(N), .ADDR_W(AW), .FIXED_PRIO(0)) dut (
        .clk(clk), .i_rst(r_rst), .i_command(r_cmd), .i_writeElseRead(r_wer),
        .i_commandSize(r_csz), .i_targetAddr(r_taddr), .i_subAddr(r_sub),
        .i_writeMask(r_mask), .i_dataClient(r_wdata), .o_busyClient(w_busy),
        .o_dataValidClient(w_dvC), .o_dataClient(w_dC), .o_grantId(w_gId),
        .o_active(w_act), .o_targetAddr(w_tAddr), .o_burstLength(w_bl),
        .i_busyMem(r_busyMem), .o_writeEnableMem(w_we), .o_readEnableMem(w_re),
        .o_dataMem(w_dm), .o_byteEnableMem(w_be), .i_dataValidMem(r_dvMem),
        .i_dataMem(r_dMem)
    );

    psx_ddr_mc_bridge #(.NUM_CLIENTS(N), .ADDR_W(AW), .FIXED_PRIO(1)) dutFixed (
        .clk(clk), .i_rst(r_rst), .i_command(r_cmd), .i_writeElseRead(r_wer),
        .i_commandSize(r_csz), .i_targetAddr(r_taddr), .i_subAddr(r_sub),
        .i_writeMask(r_mask), .i_dataClient(r_wdata), .o_busyClient(w_busyF),
        .o_dataValidClient(w_dvCF), .o_dataClient(w_dCF), .o_grantId(w_gIdF),
        .o_active(w_actF), .o_targetAddr(w_tAddrF), .o_burstLength(w_blF),
        .i_busyMem(r_busyMem), .o_writeEnableMem(w_weF), .o_readEnableMem(w_reF),
        .o_dataMem(w_dmF), .o_byteEnableMem(w_beF), .i_dataValidMem(r_dvMem),
        .i_dataMem(r_dMem)
    );

    function automatic logic [255:0] randBlk();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Byte j of a beat from lane L is enabled by halfword bit 4L + j/2.
    function automatic logic [7:0] beExp(input logic [15:0] m, input int lane);
        logic [7:0] r;
        for (int j = 0; j < 8; j++) r[j] = m[4*lane + j/2];
        return r;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        r_rst = 1'b1; r_cmd = '0; r_busyMem = 1'b0; r_dvMem = 1'b0;
        @(negedge clk);
        r_rst = 1'b0;
        for (int i = 0; i < 4; i++) mLane[i] = '0;
    endtask

    // One full transaction from client k; returns accept wait, end cycle and readEnable cycles.
    task automatic run_txn(input int k, input bit isWr, input logic [1:0] sz,
                           input logic [AW-1:0] addr, input logic [2:0] sa,
                           input logic [15:0] mask, input logic [255:0] blk,
                           input int busyFirst, input int busyPct, input int gapMax,
                           output int acceptWait, output int endCyc, output int reCyc);
        int nb, lane0, c, beat, gap;
        bit is32, b;
        logic [AW+1:0] expAddr;
        logic [2:0] expBl;
        logic [63:0] d;
        is32    = (sz != 2'd0);
        nb      = is32 ? 4 : 1;
        lane0   = is32 ? 0 : int'(sa[2:1]);
        expAddr = {addr, (is32 ? 2'b00 : sa[2:1])};
        expBl   = is32 ? 3'd4 : 3'd1;
        reCyc   = 0;
        r_cmd[k] = 1'b1; r_wer[k] = isWr; r_csz[2*k +: 2] = sz;
        r_taddr[AW*k +: AW] = addr; r_sub[3*k +: 3] = sa;
        r_mask[16*k +: 16] = mask; r_wdata[256*k +: 256] = blk;
        #1;
        acceptWait = 0;
        while (w_busy[k] !== 1'b0 && acceptWait < 50) begin
            @(negedge clk); acceptWait++;
        end
        tests++;
        if (w_busy !== ~(3'(1) << k)) begin
            fails++; $display("FAIL accept_busy: got %b want %b", w_busy, ~(3'(1) << k));
        end
        @(negedge clk);
        r_cmd[k] = 1'b0;
        tests++;
        if (w_gId !== 2'(k) || w_act !== 1'b1) begin
            fails++; $display("FAIL grant_id: got %0d act %b want %0d act 1", w_gId, w_act, k);
        end
        c = 1;
        if (isWr) begin
            beat = 0;
            while (beat < nb && c < 100) begin
                b = (c <= busyFirst) || ($urandom_range(99) < busyPct);
                r_busyMem = b;
                tests++;
                if ({w_we, w_re, w_tAddr, w_bl, w_dm, w_be} !==
                    {1'b1, 1'b0, expAddr, expBl, blk[64*(lane0+beat) +: 64], beExp(mask, lane0+beat)}) begin
                    fails++;
                    $display("FAIL write_beat%0d: got we=%b addr=%h bl=%0d d=%h be=%h want addr=%h bl=%0d d=%h be=%h",
                             beat, w_we, w_tAddr, w_bl, w_dm, w_be, expAddr, expBl,
                             blk[64*(lane0+beat) +: 64], beExp(mask, lane0+beat));
                end
                if (!b) beat++;
                @(negedge clk); c++;
            end
            r_busyMem = 1'b0;
            tests++;
            if (w_we !== 1'b0 || w_act !== 1'b0) begin
                fails++; $display("FAIL write_end: got we=%b act=%b want 0 0", w_we, w_act);
            end
        end else begin
            do begin
                b = (c <= busyFirst) || ($urandom_range(99) < busyPct);
                r_busyMem = b;
                tests++;
                if ({w_re, w_we, w_tAddr, w_bl} !== {1'b1, 1'b0, expAddr, expBl}) begin
                    fails++;
                    $display("FAIL read_req: got re=%b we=%b addr=%h bl=%0d want 1 0 %h %0d",
                             w_re, w_we, w_tAddr, w_bl, expAddr, expBl);
                end
                reCyc++;
                @(negedge clk); c++;
            end while (b && c < 100);
            r_busyMem = 1'b0;
            tests++;
            if (w_re !== 1'b0) begin
                fails++; $display("FAIL read_req_end: got re=%b want 0", w_re);
            end
            for (int i = 0; i < nb; i++) begin
                gap = $urandom_range(gapMax);
                repeat (gap) begin @(negedge clk); c++; end
                d = {$urandom, $urandom};
                r_dvMem = 1'b1; r_dMem = d;
                mLane[lane0 + i] = d;
                @(negedge clk); c++;
                r_dvMem = 1'b0;
            end
            tests++;
            if (w_dvC !== (3'(1) << k) || w_dC !== {mLane[3], mLane[2], mLane[1], mLane[0]}) begin
                fails++;
                $display("FAIL read_done: got dv=%b data=%h want dv=%b data=%h", w_dvC, w_dC,
                         3'(1) << k, {mLane[3], mLane[2], mLane[1], mLane[0]});
            end
            @(negedge clk); c++;
            tests++;
            if (w_dvC !== '0 || w_act !== 1'b0) begin
                fails++; $display("FAIL read_pulse_end: got dv=%b act=%b want 0 0", w_dvC, w_act);
            end
        end
        endCyc = c;
    endtask

    task automatic test_reset();
        @(negedge clk);
        r_rst = 1'b1; r_cmd = '1;
        repeat (3) @(negedge clk);
        #1;
        tests++;
        if (w_busy !== 3'b111) begin
            fails++; $display("FAIL reset_busy: got %b want 111", w_busy);
        end
        tests++;
        if ({w_dvC, w_dC, w_gId, w_act, w_tAddr, w_bl, w_we, w_re, w_dm, w_be} !==
            {3'b0, 256'd0, 2'd0, 1'b0, 17'd0, 3'd1, 1'b0, 1'b0, 64'd0, 8'd0}) begin
            fails++;
            $display("FAIL reset_outputs: got dv=%b act=%b addr=%h bl=%0d we=%b re=%b be=%h want all 0, bl=1",
                     w_dvC, w_act, w_tAddr, w_bl, w_we, w_re, w_be);
        end
        r_cmd = '0;
        r_rst = 1'b0;
        for (int i = 0; i < 4; i++) mLane[i] = '0;
    endtask

    task automatic test_write32();
        int aw, ec, rc;
        run_txn(0, 1'b1, 2'd1, 15'h1234, 3'd0, 16'hFFFF, randBlk(), 0, 0, 0, aw, ec, rc);
        tests++;
        if (ec !== 5) begin
            fails++; $display("FAIL write32_timing: idle at cycle %0d want 5", ec);
        end
    endtask

    task automatic test_back_to_back();
        int aw, ec, rc;
        run_txn(1, 1'b1, 2'd3, 15'(($urandom)), 3'd0, 16'($urandom), randBlk(), 0, 0, 0, aw, ec, rc);
        run_txn(0, 1'b1, 2'd1, 15'(($urandom)), 3'd0, 16'($urandom), randBlk(), 0, 0, 0, aw, ec, rc);
        tests++;
        if (aw !== 0) begin
            fails++; $display("FAIL back_to_back: accept waited %0d cycles want 0", aw);
        end
    endtask

    task automatic test_write8();
        int aw, ec, rc;
        run_txn(1, 1'b1, 2'd0, 15'h0ABC, 3'd5, 16'h0F00, randBlk(), 0, 0, 0, aw, ec, rc);
        tests++;
        if (ec !== 2) begin
            fails++; $display("FAIL write8_timing: idle at cycle %0d want 2", ec);
        end
    endtask

    task automatic test_read32();
        int aw, ec, rc;
        run_txn(1, 1'b0, 2'd1, 15'h0042, 3'd0, 16'h0, 256'd0, 3, 0, 0, aw, ec, rc);
        tests++;
        if (rc !== 4) begin
            fails++; $display("FAIL read32_req_len: readEnable %0d cycles want 4", rc);
        end
    endtask

    task automatic test_read8_merge();
        int aw, ec, rc;
        run_txn(0, 1'b0, 2'd1, 15'h0100, 3'd0, 16'h0, 256'd0, 0, 0, 1, aw, ec, rc);
        run_txn(2, 1'b0, 2'd0, 15'h0200, 3'd2, 16'h0, 256'd0, 0, 0, 2, aw, ec, rc);
    endtask

    task automatic test_round_robin();
        int q [$];
        int qf [$];
        int n;
        int expRr [4] = '{0, 1, 2, 0};
        do_reset();
        for (int k = 0; k < N; k++) begin
            r_wer[k] = 1'b1; r_csz[2*k +: 2] = 2'd1; r_mask[16*k +: 16] = 16'hFFFF;
        end
        r_cmd = '1;
        #1;
        n = 0;
        while ((q.size() < 4 || qf.size() < 4) && n < 40) begin
            for (int k = 0; k < N; k++) begin
                if (w_busy !== 3'b111 && w_busy[k] === 1'b0) q.push_back(k);
                if (w_busyF !== 3'b111 && w_busyF[k] === 1'b0) qf.push_back(k);
            end
            @(negedge clk); n++;
        end
        r_cmd = '0;
        n = 0;
        while ((w_act || w_actF) && n < 20) begin @(negedge clk); n++; end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (q.size() <= i || q[i] !== expRr[i]) begin
                fails++; $display("FAIL rr_grant%0d: got %0d want %0d", i, (q.size() > i) ? q[i] : -1, expRr[i]);
            end
            tests++;
            if (qf.size() <= i || qf[i] !== 0) begin
                fails++; $display("FAIL fixed_grant%0d: got %0d want 0", i, (qf.size() > i) ? qf[i] : -1);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        r_cmd[0] = 1'b1; r_wer[0] = 1'b1; r_csz[1:0] = 2'd1;
        r_mask[15:0] = 16'hFFFF; r_wdata[255:0] = randBlk();
        #1;
        n = 0;
        while (w_busy[0] !== 1'b0 && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        r_cmd[0] = 1'b0;
        repeat (2) @(negedge clk);
        r_rst = 1'b1;
        @(negedge clk);
        tests++;
        if ({w_we, w_re, w_act, w_busy} !== {1'b0, 1'b0, 1'b0, 3'b111}) begin
            fails++; $display("FAIL reset_mid: got we=%b re=%b act=%b busy=%b want 0 0 0 111",
                              w_we, w_re, w_act, w_busy);
        end
        r_rst = 1'b0;
        for (int i = 0; i < 4; i++) mLane[i] = '0;
        r_dvMem = 1'b1; r_dMem = {$urandom, $urandom};
        @(negedge clk);
        r_dvMem = 1'b0;
        @(negedge clk);
        tests++;
        if (w_dC !== 256'd0 || w_dvC !== '0 || w_act !== 1'b0) begin
            fails++; $display("FAIL stray_valid: got data=%h dv=%b act=%b want 0 0 0", w_dC, w_dvC, w_act);
        end
    endtask

    task automatic test_random();
        int aw, ec, rc;
        logic [15:0] m;
        for (int t = 0; t < 40; t++) begin
            m = ($urandom_range(7) == 0) ? 16'h0 : 16'($urandom);
            run_txn(int'($urandom_range(N-1)), 1'($urandom), 2'($urandom), 15'($urandom),
                    3'($urandom), m, randBlk(), 0, 30, 2, aw, ec, rc);
        end
    endtask

    initial begin
        test_reset();
        test_write32();
        test_back_to_back();
        test_write8();
        test_read32();
        test_read8_merge();
        test_round_robin();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
